countdown_timer: RTL

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_pkg.sv | 29 ++
 rtl/countdown_timer_field.sv | 38 +++
 rtl/countdown_timer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/countdown_pkg.sv
// ============================================================================
// Module      : countdown_pkg
// Description : Shared state encoding and field limits for the countdown timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package countdown_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SET     = 3'd1,
    ST_RUN     = 3'd2,
    ST_PAUSED  = 3'd3,
    ST_EXPIRED = 3'd4
  } state_t;

  localparam logic [7:0] SEC_MAX = 8'd59;
  localparam logic [7:0] MIN_MAX = 8'd59;
  localparam logic [7:0] HRS_MAX = 8'd23;

  function automatic logic time_is_zero(input logic [7:0] h, input logic [7:0] m,
                                        input logic [7:0] s);
    return (h == 8'd0) && (m == 8'd0) && (s == 8'd0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/countdown_timer_field.sv
// ============================================================================
// Module      : mod_down_field
// Description : One modulo time field with load/inc/dec/clear and borrow-out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_down_field (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       inc,
  input  logic       dec,
  input  logic [7:0] maxval,
  output logic [7:0] value,
  output logic       borrow
);

  // Borrow is combinational so the whole chain settles within one edge.
  assign borrow = dec && (value == 8'd0);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      value <= 8'd0;
    end else if (load) begin
      value <= load_val;
    end else if (dec) begin
      value <= (value == 8'd0) ? maxval : value - 8'd1;
    end else if (inc) begin
      value <= (value >= maxval) ? 8'd0 : value + 8'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/countdown_timer.sv
// ============================================================================
// Module      : countdown_timer
// Description : H:M:S countdown timer with SET/RUN/PAUSED/EXPIRED control.
//               Define COUNTDOWN_BLINK_EN to make alarm_led blink on tick_en.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module countdown_timer
  import countdown_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 2
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       tick_en,
  input  logic       set_en,
  input  logic       set_hrs1min0,
  input  logic       inc,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  output logic [7:0] sec,
  output logic [7:0] min,
  output logic [7:0] hrs,
  output logic       running,
  output logic       expired,
  output logic       alarm_led
);

  localparam logic [7:0] PRESC_LAST = 8'(TICKS_PER_SEC - 1);

  state_t     r_state;
  logic [7:0] r_presc;

  logic w_tick_run;
  logic w_dec;
  logic w_time_one;
  logic w_time_zero;
  logic w_expire_now;
  logic w_min_inc;
  logic w_hrs_inc;
  logic w_sec_borrow;
  logic w_min_borrow;
  logic w_hrs_borrow;

  assign w_time_zero  = time_is_zero(hrs, min, sec);
  assign w_time_one   = (hrs == 8'd0) && (min == 8'd0) && (sec == 8'd1);
  assign w_tick_run   = (r_state == ST_RUN) && tick_en;
  // Gating on a non-zero time keeps the count from ever wrapping below zero.
  assign w_dec        = w_tick_run && (r_presc == PRESC_LAST) && !w_time_zero;
  assign w_expire_now = w_dec && (w_time_one || w_hrs_borrow);
  assign w_min_inc    = (r_state == ST_SET) && inc && !set_hrs1min0;
  assign w_hrs_inc    = (r_state == ST_SET) && inc && set_hrs1min0;

  mod_down_field u_sec (
    .clk      (CLK),
    .rst      (reset),
    .clear    (clear),
    .load     (1'b0),
    .load_val (8'd0),
    .inc      (1'b0),
    .dec      (w_dec),
    .maxval   (SEC_MAX),
    .value    (sec),
    .borrow   (w_sec_borrow)
  );

  mod_down_field u_min (
    .clk      (CLK),
    .rst      (reset),
    .clear    (clear),
    .load     (1'b0),
    .load_val (8'd0),
    .inc      (w_min_inc),
    .dec      (w_sec_borrow),
    .maxval   (MIN_MAX),
    .value    (min),
    .borrow   (w_min_borrow)
  );

  mod_down_field u_hrs (
    .clk      (CLK),
    .rst      (reset),
    .clear    (clear),
    .load     (1'b0),
    .load_val (8'd0),
    .inc      (w_hrs_inc),
    .dec      (w_min_borrow),
    .maxval   (HRS_MAX),
    .value    (hrs),
    .borrow   (w_hrs_borrow)
  );

  // Prescaler only moves in RUN, so PAUSED keeps the tick phase intact.
  always_ff @(posedge CLK) begin
    if (reset || clear) begin
      r_presc <= 8'd0;
    end else if (w_tick_run) begin
      r_presc <= (r_presc == PRESC_LAST) ? 8'd0 : r_presc + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset || clear) begin
      r_state   <= ST_IDLE;
      running   <= 1'b0;
      expired   <= 1'b0;
      alarm_led <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (set_en) begin
            r_state <= ST_SET;
          end else if (start && !w_time_zero) begin
            r_state <= ST_RUN;
            running <= 1'b1;
          end
        end
        ST_SET: begin
          if (!set_en) begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          // Expiry outranks pause so a zero time never sits in PAUSED.
          if (w_expire_now) begin
            r_state <= ST_EXPIRED;
            running <= 1'b0;
            expired <= 1'b1;
`ifdef COUNTDOWN_BLINK_EN
            alarm_led <= 1'b0;
`else
            alarm_led <= 1'b1;
`endif
          end else if (pause) begin
            r_state <= ST_PAUSED;
            running <= 1'b0;
          end
        end
        ST_PAUSED: begin
          if (start) begin
            r_state <= ST_RUN;
            running <= 1'b1;
          end
        end
        ST_EXPIRED: begin
`ifdef COUNTDOWN_BLINK_EN
          if (tick_en) begin
            alarm_led <= ~alarm_led;
          end
`else
          alarm_led <= 1'b1;
`endif
        end
        default: begin
          r_state   <= ST_IDLE;
          running   <= 1'b0;
          expired   <= 1'b0;
          alarm_led <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
